// File: rtl/mips_dmem_mmio.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus memory-mapped
// free-running timer with compare/IRQ flag and a byte TX FIFO drained by valid/ready.
module mips_dmem_mmio #(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0] ADDR_TIMER  = 8'h00;
    localparam logic [7:0] ADDR_CMP    = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_TXDATA = 8'h0C;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          ram_hit_s;
    logic          io_hit_s;
    logic [AW-1:0] ram_addr_s;
    logic          ram_wr_s;
    logic          timer_wr_s;
    logic          cmp_wr_s;
    logic          status_wr_s;
    logic          push_req_s;
    logic          unused_addr_s;

    assign ram_hit_s     = ~a[31];
    assign io_hit_s      = a[31];
    assign ram_addr_s    = a[AW+1:2];
    assign ram_wr_s      = we & ram_hit_s;
    assign timer_wr_s    = we & io_hit_s & (a[7:0] == ADDR_TIMER);
    assign cmp_wr_s      = we & io_hit_s & (a[7:0] == ADDR_CMP);
    assign status_wr_s   = we & io_hit_s & (a[7:0] == ADDR_STATUS);
    assign push_req_s    = we & io_hit_s & (a[7:0] == ADDR_TXDATA);
    assign unused_addr_s = ^{a[30:8], a[1:0]};

    // ------------------------------------------------------------------
    // RAM (contents intentionally not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram_r [DEPTH];

    // RAM store port
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            ram_r[ram_addr_s] <= wd;
        end
    end

    // ------------------------------------------------------------------
    // Timer, compare and IRQ flag
    // ------------------------------------------------------------------
    logic [31:0] timer_r;
    logic [31:0] cmp_r;
    logic        irq_flag_r;
    logic        irq_r;
    logic        match_s;

    assign match_s = (timer_r == cmp_r);

    // Timer counts every cycle; a CPU store replaces that cycle's increment
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= 32'h0000_0000;
        end else if (timer_wr_s) begin
            timer_r <= wd;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_r <= 32'hFFFF_FFFF;
        end else if (cmp_wr_s) begin
            cmp_r <= wd;
        end else begin
            cmp_r <= cmp_r;
        end
    end

    // IRQ flag: a match in the same cycle beats a write-one-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (match_s) begin
                irq_flag_r <= 1'b1;
            end else if (status_wr_s && wd[0]) begin
                irq_flag_r <= 1'b0;
            end else begin
                irq_flag_r <= irq_flag_r;
            end
            irq_r <= irq_flag_r;
        end
    end

    assign irq = irq_r;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          tx_ovf_r;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_s;

    assign full_s  = (count_r == CW'(FIFO_DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign pop_s   = tx_valid & tx_ready;
    // A full FIFO still takes a byte when the consumer frees a slot this cycle
    assign push_s  = push_req_s & (~full_s | pop_s);
    assign ovf_s   = push_req_s & full_s & ~pop_s;

    // Next occupancy from push/pop combination
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= wd[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky overflow: a new overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_r <= 1'b0;
        end else if (ovf_s) begin
            tx_ovf_r <= 1'b1;
        end else if (status_wr_s && wd[3]) begin
            tx_ovf_r <= 1'b0;
        end else begin
            tx_ovf_r <= tx_ovf_r;
        end
    end

    assign tx_valid = ~empty_s;
    assign tx_data  = tx_valid ? fifo_r[rd_ptr_r] : 8'h00;

    // ------------------------------------------------------------------
    // Load data mux (zero latency)
    // ------------------------------------------------------------------
    logic [3:0]  count4_s;
    logic [31:0] status_s;

    assign count4_s = 4'(count_r);
    assign status_s = {24'h00_0000, count4_s, tx_ovf_r, empty_s, full_s, irq_flag_r};

    // Load path: RAM word or I/O register, unmapped and TXDATA read as zero
    always_comb begin
        rd = 32'h0000_0000;
        if (io_hit_s) begin
            case (a[7:0])
                ADDR_TIMER:  rd = timer_r;
                ADDR_CMP:    rd = cmp_r;
                ADDR_STATUS: rd = status_s;
                default:     rd = 32'h0000_0000;
            endcase
        end else begin
            rd = ram_r[ram_addr_s];
        end
    end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: expected values queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_mips_dmem_mmio;

    localparam logic [31:0] A_TIMER  = 32'h8000_0000;
    localparam logic [31:0] A_CMP    = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_TXDATA = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic        irq;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] got, exp;

    mips_dmem_mmio dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
        .irq(irq), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #10 clk = ~clk;

    // Called in the low phase; returns at the next falling edge
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; we = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        logic [31:0] addrs [3];
        logic [31:0] vals  [3];
        addrs = '{A_TIMER, A_CMP, A_STATUS};
        vals  = '{32'h0, 32'hFFFF_FFFF, 32'h0000_0004};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(vals[i]);
            a = addrs[i]; #1; got = rd; exp = exp_q.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s_reg%0d got=%h want=%h", tag, i, got, exp);
            end
        end
        vectors++;
        if ({irq, tx_valid, tx_data} !== 10'h000) begin
            miscompares++;
            $display("FAIL %s_outputs irq=%b tx_valid=%b tx_data=%h want 0/0/00", tag, irq, tx_valid, tx_data);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_state("reset");
    endtask

    task automatic test_ram();
        logic [31:0] raddr [3];
        raddr = '{32'h10, 32'h13, 32'h110};
        bus_write(32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hDEAD_BEEF);
            a = raddr[i]; #1; got = rd; exp = exp_q.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ram_read_%h got=%h want=%h", raddr[i], got, exp);
            end
        end
        bus_write(32'h20, 32'h1111_1111);
        exp_q.push_back(32'h1111_1111);
        we = 1'b1; a = 32'h20; wd = 32'h2222_2222; #1;
        got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ram_rdw_old got=%h want=%h", got, exp);
        end
        @(negedge clk); we = 1'b0;
        exp_q.push_back(32'h2222_2222);
        a = 32'h20; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ram_rdw_new got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_io_decode();
        do_reset();
        bus_write(32'h8000_0010, 32'h0000_0005);
        exp_q.push_back(32'h0);
        a = A_TXDATA; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL txdata_read got=%h want=%h", got, exp); end
        exp_q.push_back(32'h0);
        a = 32'h8000_0010; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL unmapped_read got=%h want=%h", got, exp); end
        exp_q.push_back(32'hFFFF_FFFF);
        a = A_CMP; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL unmapped_write_cmp got=%h want=%h", got, exp); end
    endtask

    task automatic test_timer();
        do_reset();
        repeat (5) @(negedge clk);
        exp_q.push_back(32'd5);
        a = A_TIMER; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL timer_5 got=%h want=%h", got, exp); end
        bus_write(A_TIMER, 32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFE);
        a = A_TIMER; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL timer_load got=%h want=%h", got, exp); end
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h0);
        a = A_TIMER; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL timer_wrap got=%h want=%h", got, exp); end
    endtask

    task automatic test_irq();
        logic [31:0] st_exp [5];
        logic        irq_exp [5];
        do_reset();
        bus_write(A_CMP, 32'd20);
        repeat (19) @(negedge clk);
        // steps: TIMER=20, flag set, irq follows, W1C clears flag, irq drops
        st_exp  = '{32'h4, 32'h5, 32'h5, 32'h4, 32'h4};
        irq_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 2 || i == 4) @(negedge clk);
            if (i == 3) bus_write(A_STATUS, 32'h1);
            exp_q.push_back(st_exp[i]);
            a = A_STATUS; #1; got = rd; exp = exp_q.pop_front(); vectors++;
            if (got !== exp || irq !== irq_exp[i]) begin
                miscompares++;
                $display("FAIL irq_step%0d status=%h irq=%b want status=%h irq=%b", i, got, irq, exp, irq_exp[i]);
            end
        end
        bus_write(A_CMP, 32'd100);
        bus_write(A_TIMER, 32'd100);
        bus_write(A_STATUS, 32'h1);
        exp_q.push_back(32'h5);
        a = A_STATUS; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL irq_set_wins got=%h want=%h", got, exp); end
    endtask

    task automatic drain_fifo(input string tag);
        tx_ready = 1'b1;
        for (int c = 0; c < 12 && byte_q.size() > 0; c++) begin
            if (tx_valid) begin
                exp = {24'h0, byte_q.pop_front()}; vectors++;
                if (tx_data !== exp[7:0]) begin
                    miscompares++;
                    $display("FAIL %s_byte got=%h want=%h", tag, tx_data, exp[7:0]);
                end
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        vectors++;
        if (byte_q.size() != 0 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain_end left=%0d tx_valid=%b want 0/0", tag, byte_q.size(), tx_valid);
            byte_q.delete();
        end
    endtask

    task automatic test_fifo();
        do_reset();
        vectors++;
        if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL fifo_empty_valid got=%b want=0", tx_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) byte_q.push_back(8'h41 + 8'(i));
            bus_write(A_TXDATA, 32'h41 + i);
            if (i == 0) begin
                vectors++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
                    miscompares++;
                    $display("FAIL fifo_first_push valid=%b data=%h want 1/41", tx_valid, tx_data);
                end
            end
            if (i == 3) begin
                exp_q.push_back(32'h42);
                a = A_STATUS; #1; got = rd; exp = exp_q.pop_front(); vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL fifo_full_status got=%h want=%h", got, exp); end
            end
        end
        exp_q.push_back(32'h4A);
        a = A_STATUS; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL fifo_ovf_status got=%h want=%h", got, exp); end
        bus_write(A_STATUS, 32'h8);
        exp_q.push_back(32'h42);
        a = A_STATUS; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL fifo_ovf_clear got=%h want=%h", got, exp); end
        drain_fifo("fifo_order");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            byte_q.push_back(8'h50 + 8'(i));
            bus_write(A_TXDATA, 32'h50 + i);
        end
        byte_q.push_back(8'h54);
        exp = {24'h0, byte_q.pop_front()}; vectors++;
        if (tx_data !== exp[7:0]) begin miscompares++; $display("FAIL b2b_head got=%h want=%h", tx_data, exp[7:0]); end
        tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'h54);
        tx_ready = 1'b0;
        exp_q.push_back(32'h42);
        a = A_STATUS; #1; got = rd; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL b2b_status got=%h want=%h", got, exp); end
        drain_fifo("b2b_order");
    endtask

    task automatic test_reset_midtransfer();
        do_reset();
        bus_write(A_CMP, 32'h1234);
        for (int i = 0; i < 3; i++) bus_write(A_TXDATA, 32'h60 + i);
        vectors++;
        if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL mid_queued valid=%b want=1", tx_valid); end
        do_reset();
        check_reset_state("mid_reset");
    endtask

    initial begin
        test_reset();
        test_ram();
        test_io_decode();
        test_timer();
        test_irq();
        test_fifo();
        test_back_to_back();
        test_reset_midtransfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
